// File: rtl/accel_avalon_loader.sv
// accel_avalon_loader: Avalon-MM master that runs a soft-reset / coeff load / pixel load / result readback job per start pulse
module accel_avalon_loader #(
  parameter int AddressWidth    = 10,
  parameter int DataWidth       = 32,
  parameter int AddrRoutingBits = 2,
  parameter int CountWidth      = 16,
  parameter int ReadLatency     = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    Start,
  input  logic [CountWidth-1:0]   CoeffCount,
  input  logic [CountWidth-1:0]   PixelCount,
  input  logic [CountWidth-1:0]   ResultCount,
  output logic                    Busy,
  output logic                    Done,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic [DataWidth-1:0]    InData,
  output logic                    ResValid,
  input  logic                    ResReady,
  output logic [DataWidth-1:0]    ResData,
  output logic [AddressWidth-1:0] AvmAddress,
  output logic                    AvmWrite,
  output logic                    AvmRead,
  output logic [DataWidth-1:0]    AvmWriteData,
  input  logic [DataWidth-1:0]    AvmReadData,
  input  logic                    AvmWaitRequest
);
  typedef enum logic [2:0] {IDLE, CMD_RST, LD_COEFF, LD_PIXEL, RD_RES, FIN} state_e;
  localparam int SubW = AddressWidth - AddrRoutingBits;
  localparam int LatW = $clog2(ReadLatency + 1);
  localparam logic [AddrRoutingBits-1:0] RegCoeff  = AddrRoutingBits'(1);
  localparam logic [AddrRoutingBits-1:0] RegData   = AddrRoutingBits'(2);
  localparam logic [AddrRoutingBits-1:0] RegResult = AddrRoutingBits'(3);
  state_e                  state_q, state_d;
  logic [CountWidth-1:0]   coeff_n_q, coeff_n_d, pix_n_q, pix_n_d, res_n_q, res_n_d;
  logic [CountWidth-1:0]   wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [LatW-1:0]         lat_q, lat_d;
  logic                    avm_write_q, avm_write_d, avm_read_q, avm_read_d;
  logic [AddressWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0]    wdata_q, wdata_d, res_data_q, res_data_d;
  logic                    res_valid_q, res_valid_d;
  logic                    wr_left, wr_acc, in_ready, in_fire, res_fire, rd_acc, rd_busy, rd_issue, capture;
  state_e                  after_cmd, after_coeff, after_pix;
  // Handshake qualifiers shared by the write and read phases
  always_comb begin
    wr_left     = wr_idx_q != (state_q == LD_COEFF ? coeff_n_q : pix_n_q);
    wr_acc      = avm_write_q & ~AvmWaitRequest;
    in_ready    = (state_q == LD_COEFF || state_q == LD_PIXEL) & wr_left & (~avm_write_q | ~AvmWaitRequest);
    in_fire     = InValid & in_ready;
    res_fire    = res_valid_q & ResReady;
    rd_acc      = avm_read_q & ~AvmWaitRequest;
    rd_busy     = avm_read_q | (lat_q != '0);
    rd_issue    = (state_q == RD_RES) & ~rd_busy & (rd_idx_q != res_n_q) & (~res_valid_q | ResReady);
    capture     = lat_q == LatW'(1);
    after_pix   = res_n_q != '0 ? RD_RES : FIN;
    after_coeff = pix_n_q != '0 ? LD_PIXEL : after_pix;
    after_cmd   = coeff_n_q != '0 ? LD_COEFF : after_coeff;
  end
  // Next-state logic: phase sequencing, request generation and result capture
  always_comb begin
    state_d     = state_q;
    coeff_n_d   = coeff_n_q;
    pix_n_d     = pix_n_q;
    res_n_d     = res_n_q;
    wr_idx_d    = in_fire ? wr_idx_q + 1'b1 : wr_idx_q;
    rd_idx_d    = rd_issue ? rd_idx_q + 1'b1 : rd_idx_q;
    lat_d       = rd_acc ? LatW'(ReadLatency) : lat_q != '0 ? lat_q - 1'b1 : lat_q;
    avm_write_d = in_fire ? 1'b1 : wr_acc ? 1'b0 : avm_write_q;
    avm_read_d  = rd_issue ? 1'b1 : rd_acc ? 1'b0 : avm_read_q;
    wdata_d     = in_fire ? InData : wdata_q;
    addr_d      = in_fire ? (state_q == LD_COEFF ? {RegCoeff, wr_idx_q[SubW-1:0]} : {RegData, {SubW{1'b0}}})
                : rd_issue ? {RegResult, rd_idx_q[SubW-1:0]} : addr_q;
    res_valid_d = capture ? 1'b1 : res_fire ? 1'b0 : res_valid_q;
    res_data_d  = capture ? AvmReadData : res_data_q;
    case (state_q)
      IDLE: if (Start) begin
        state_d     = CMD_RST;
        coeff_n_d   = CoeffCount;
        pix_n_d     = PixelCount;
        res_n_d     = ResultCount;
        wr_idx_d    = '0;
        rd_idx_d    = '0;
        avm_write_d = 1'b1;
        addr_d      = '0;
        wdata_d     = '0;
      end
      CMD_RST:  state_d = wr_acc ? after_cmd : state_q;
      LD_COEFF: if (wr_acc && !wr_left) begin
        state_d  = after_coeff;
        wr_idx_d = '0;
      end
      LD_PIXEL: if (wr_acc && !wr_left) begin
        state_d  = after_pix;
        wr_idx_d = '0;
      end
      RD_RES:   state_d = (res_fire && rd_idx_q == res_n_q && !rd_busy) ? FIN : state_q;
      FIN:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end
  // State and datapath registers; reset aborts any in-flight request immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      coeff_n_q   <= '0;
      pix_n_q     <= '0;
      res_n_q     <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      lat_q       <= '0;
      avm_write_q <= 1'b0;
      avm_read_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      coeff_n_q   <= coeff_n_d;
      pix_n_q     <= pix_n_d;
      res_n_q     <= res_n_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      lat_q       <= lat_d;
      avm_write_q <= avm_write_d;
      avm_read_q  <= avm_read_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end
  assign Busy         = state_q inside {CMD_RST, LD_COEFF, LD_PIXEL, RD_RES};
  assign Done         = state_q == FIN;
  assign InReady      = in_ready;
  assign ResValid     = res_valid_q;
  assign ResData      = res_data_q;
  assign AvmAddress   = addr_q;
  assign AvmWrite     = avm_write_q;
  assign AvmRead      = avm_read_q;
  assign AvmWriteData = wdata_q;
endmodule

// File: tb/tb_accel_avalon_loader.sv
// tb_accel_avalon_loader: directed scenario bench for the Avalon job loader
module tb_accel_avalon_loader;
  logic        clk = 0, reset = 0, Start = 0;
  logic [15:0] CoeffCount = 0, PixelCount = 0, ResultCount = 0;
  logic        Busy, Done, InReady, ResValid, AvmWrite, AvmRead;
  logic        InValid = 0, ResReady = 1, AvmWaitRequest = 0;
  logic [31:0] InData = 0, ResData, AvmWriteData, AvmReadData = 0;
  logic [9:0]  AvmAddress;

  accel_avalon_loader dut (
    .clk(clk), .reset(reset), .Start(Start), .CoeffCount(CoeffCount), .PixelCount(PixelCount),
    .ResultCount(ResultCount), .Busy(Busy), .Done(Done), .InValid(InValid), .InReady(InReady),
    .InData(InData), .ResValid(ResValid), .ResReady(ResReady), .ResData(ResData),
    .AvmAddress(AvmAddress), .AvmWrite(AvmWrite), .AvmRead(AvmRead), .AvmWriteData(AvmWriteData),
    .AvmReadData(AvmReadData), .AvmWaitRequest(AvmWaitRequest)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  logic [31:0] src_q[$];
  logic [9:0]  wa[$], ra[$];
  logic [31:0] wd[$], rs[$];
  int          wc[$];
  int src_ptr = 0, cyc = 0, done_n = 0, done_cyc = 0;
  int stall_n = 0, stall_used = 0, hold_n = 0, hold_used = 0;
  logic [9:0] stall_addr = 10'h3ff;
  int stall_good = 0, unstable = 0, rd_res_overlap = 0, wr_rd_both = 0;
  logic ret_pend = 0;
  logic [31:0] ret_val = 0;
  logic prev_stall = 0, prev_w = 0, prev_r = 0;
  logic [9:0] prev_a = 0;
  logic [31:0] prev_d = 0;

  // Stimulus sources, slave model and result sink, all driven just after the clock edge
  always @(posedge clk) begin
    #1;
    InValid = src_ptr < src_q.size();
    InData = InValid ? src_q[src_ptr] : 32'hBAD0_0000;
    AvmWaitRequest = 0;
    if (AvmWrite && AvmAddress == stall_addr && stall_used < stall_n) begin
      AvmWaitRequest = 1;
      stall_used++;
    end
    ResReady = 1;
    if (ResValid && hold_used < hold_n) begin
      ResReady = 0;
      hold_used++;
    end
    AvmReadData = ret_pend ? ret_val : 32'hDEAD_BEEF;
  end

  // Transaction monitor sampled mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (Start && !Busy && reset) src_ptr = 0;
    else if (InValid && InReady) src_ptr++;
    if (AvmWrite && !AvmWaitRequest) begin
      wa.push_back(AvmAddress);
      wd.push_back(AvmWriteData);
      wc.push_back(cyc);
    end
    if (AvmRead && !AvmWaitRequest) ra.push_back(AvmAddress);
    ret_pend = AvmRead && !AvmWaitRequest;
    ret_val = 32'hA000_0000 | {22'd0, AvmAddress};
    if (ResValid && ResReady) rs.push_back(ResData);
    if (Done) begin
      done_n++;
      done_cyc = cyc;
    end
    if (AvmWrite && AvmWaitRequest && AvmAddress == 10'h102 && AvmWriteData == 32'hC000_0002 && !InReady)
      stall_good++;
    if (prev_stall && (AvmAddress != prev_a || AvmWriteData != prev_d || AvmWrite != prev_w || AvmRead != prev_r))
      unstable++;
    prev_stall = (AvmWrite || AvmRead) && AvmWaitRequest;
    prev_a = AvmAddress;
    prev_d = AvmWriteData;
    prev_w = AvmWrite;
    prev_r = AvmRead;
    if (AvmRead && ResValid) rd_res_overlap++;
    if (AvmWrite && AvmRead) wr_rd_both++;
  end

  function automatic logic [9:0] exp_addr(input int i, input int c);
    return i == 0 ? 10'h000 : i <= c ? 10'h100 + 10'(i - 1) : 10'h200;
  endfunction

  function automatic logic [31:0] exp_data(input int i, input int c);
    return i == 0 ? 32'h0 : i <= c ? 32'hC000_0000 + 32'(i - 1) : 32'hD000_0000 + 32'(i - 1 - c);
  endfunction

  task automatic load_src(input int c, input int p);
    src_q.delete();
    for (int i = 0; i < c; i++) src_q.push_back(32'hC000_0000 + 32'(i));
    for (int i = 0; i < p; i++) src_q.push_back(32'hD000_0000 + 32'(i));
  endtask

  task automatic pulse_start(input int c, input int p, input int r);
    @(posedge clk); #1;
    CoeffCount = 16'(c);
    PixelCount = 16'(p);
    ResultCount = 16'(r);
    Start = 1;
    @(posedge clk); #1;
    Start = 0;
  endtask

  task automatic wait_done(output bit to);
    to = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (Done) begin
        to = 0;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    bit found;
    @(negedge clk);
    checks++;
    if ({Busy, Done, AvmWrite, AvmRead, InReady, ResValid} !== 6'b0)
      begin errs++; $display("FAIL reset_ctrl: got %b expected 000000", {Busy, Done, AvmWrite, AvmRead, InReady, ResValid}); end
    checks++;
    if ({AvmAddress, AvmWriteData, ResData} !== 74'b0)
      begin errs++; $display("FAIL reset_data: got %h/%h/%h expected 0", AvmAddress, AvmWriteData, ResData); end
    #2 reset = 1;
    load_src(1, 8);
    pulse_start(1, 8, 1);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (AvmWrite && AvmAddress == 10'h200) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (found !== 1) begin errs++; $display("FAIL reset_reach_pixel: got %b expected 1", found); end
    #2 reset = 0;
    #1;
    checks++;
    if ({AvmWrite, Busy, InReady, AvmRead} !== 4'b0)
      begin errs++; $display("FAIL reset_abort: got %b expected 0000", {AvmWrite, Busy, InReady, AvmRead}); end
    @(negedge clk); #2 reset = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({Busy, Done, AvmWrite, InReady} !== 4'b0)
      begin errs++; $display("FAIL reset_idle: got %b expected 0000", {Busy, Done, AvmWrite, InReady}); end
  endtask

  task automatic test_basic;
    bit to;
    int b = wa.size(), rb = ra.size(), sb = rs.size(), d0 = done_n;
    load_src(4, 8);
    pulse_start(4, 8, 2);
    checks++;
    if ({Busy, AvmWrite, AvmAddress, AvmWriteData} !== {1'b1, 1'b1, 10'h0, 32'h0})
      begin errs++; $display("FAIL basic_cmd: got %b %b %h %h expected 1 1 000 0", Busy, AvmWrite, AvmAddress, AvmWriteData); end
    wait_done(to);
    checks++;
    if (to !== 0) begin errs++; $display("FAIL basic_timeout: got %b expected 0", to); end
    checks++;
    if (Done !== 0 || Busy !== 0) begin errs++; $display("FAIL basic_after_done: got %b%b expected 00", Done, Busy); end
    checks++;
    if (wa.size() - b !== 13) begin errs++; $display("FAIL basic_nwrites: got %0d expected 13", wa.size() - b); end
    else for (int i = 0; i < 13; i++) begin
      checks++;
      if (wa[b+i] !== exp_addr(i, 4) || wd[b+i] !== exp_data(i, 4))
        begin errs++; $display("FAIL basic_write%0d: got %h/%h expected %h/%h", i, wa[b+i], wd[b+i], exp_addr(i, 4), exp_data(i, 4)); end
    end
    checks++;
    if (ra.size() - rb !== 2) begin errs++; $display("FAIL basic_nreads: got %0d expected 2", ra.size() - rb); end
    else for (int j = 0; j < 2; j++) begin
      checks++;
      if (ra[rb+j] !== 10'h300 + 10'(j)) begin errs++; $display("FAIL basic_read%0d: got %h expected %h", j, ra[rb+j], 10'h300 + 10'(j)); end
    end
    checks++;
    if (rs.size() - sb !== 2) begin errs++; $display("FAIL basic_nres: got %0d expected 2", rs.size() - sb); end
    else for (int j = 0; j < 2; j++) begin
      checks++;
      if (rs[sb+j] !== 32'hA000_0300 + 32'(j)) begin errs++; $display("FAIL basic_res%0d: got %h expected %h", j, rs[sb+j], 32'hA000_0300 + 32'(j)); end
    end
    checks++;
    if (done_n - d0 !== 1) begin errs++; $display("FAIL basic_done: got %0d expected 1", done_n - d0); end
  endtask

  task automatic test_stall;
    bit to;
    int b = wa.size(), g0 = stall_good;
    stall_addr = 10'h102;
    stall_n = stall_used + 3;
    load_src(4, 2);
    pulse_start(4, 2, 1);
    wait_done(to);
    checks++;
    if (to !== 0) begin errs++; $display("FAIL stall_timeout: got %b expected 0", to); end
    checks++;
    if (stall_good - g0 !== 3) begin errs++; $display("FAIL stall_held: got %0d expected 3", stall_good - g0); end
    checks++;
    if (unstable !== 0) begin errs++; $display("FAIL stall_stable: got %0d expected 0", unstable); end
    checks++;
    if (wa.size() - b !== 7) begin errs++; $display("FAIL stall_nwrites: got %0d expected 7", wa.size() - b); end
    else for (int i = 0; i < 7; i++) begin
      checks++;
      if (wa[b+i] !== exp_addr(i, 4) || wd[b+i] !== exp_data(i, 4))
        begin errs++; $display("FAIL stall_write%0d: got %h/%h expected %h/%h", i, wa[b+i], wd[b+i], exp_addr(i, 4), exp_data(i, 4)); end
    end
    stall_addr = 10'h3ff;
  endtask

  task automatic test_zero;
    bit to;
    int b = wa.size(), rb = ra.size();
    load_src(0, 0);
    pulse_start(0, 0, 0);
    wait_done(to);
    checks++;
    if (to !== 0) begin errs++; $display("FAIL zero_timeout: got %b expected 0", to); end
    checks++;
    if (wa.size() - b !== 1 || ra.size() - rb !== 0)
      begin errs++; $display("FAIL zero_traffic: got %0d writes %0d reads expected 1 0", wa.size() - b, ra.size() - rb); end
    else begin
      checks++;
      if (done_cyc !== wc[b] + 1) begin errs++; $display("FAIL zero_done_latency: got %0d expected %0d", done_cyc - wc[b], 1); end
    end
  endtask

  task automatic test_backpressure;
    bit to;
    int rb = ra.size(), sb = rs.size(), o0 = rd_res_overlap, h0 = hold_used;
    hold_n = hold_used + 5;
    load_src(0, 1);
    pulse_start(0, 1, 3);
    wait_done(to);
    checks++;
    if (to !== 0) begin errs++; $display("FAIL bp_timeout: got %b expected 0", to); end
    checks++;
    if (hold_used - h0 !== 5) begin errs++; $display("FAIL bp_hold_applied: got %0d expected 5", hold_used - h0); end
    checks++;
    if (rd_res_overlap - o0 !== 0) begin errs++; $display("FAIL bp_read_while_pending: got %0d expected 0", rd_res_overlap - o0); end
    checks++;
    if (ra.size() - rb !== 3 || rs.size() - sb !== 3)
      begin errs++; $display("FAIL bp_counts: got %0d reads %0d results expected 3 3", ra.size() - rb, rs.size() - sb); end
    else for (int j = 0; j < 3; j++) begin
      checks++;
      if (ra[rb+j] !== 10'h300 + 10'(j) || rs[sb+j] !== 32'hA000_0300 + 32'(j))
        begin errs++; $display("FAIL bp_res%0d: got %h/%h expected %h/%h", j, ra[rb+j], rs[sb+j], 10'h300 + 10'(j), 32'hA000_0300 + 32'(j)); end
    end
    checks++;
    if (wr_rd_both !== 0) begin errs++; $display("FAIL wr_rd_exclusive: got %0d expected 0", wr_rd_both); end
  endtask

  task automatic test_start_busy;
    bit to, found;
    int b = wa.size(), rb = ra.size(), d0 = done_n;
    load_src(4, 2);
    pulse_start(4, 2, 1);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (AvmWrite && AvmAddress[9:8] == 2'd1) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (found !== 1) begin errs++; $display("FAIL busy_reach_coeff: got %b expected 1", found); end
    pulse_start(9, 9, 9);
    wait_done(to);
    checks++;
    if (to !== 0) begin errs++; $display("FAIL busy_timeout: got %b expected 0", to); end
    checks++;
    if (wa.size() - b !== 7 || ra.size() - rb !== 1)
      begin errs++; $display("FAIL busy_traffic: got %0d writes %0d reads expected 7 1", wa.size() - b, ra.size() - rb); end
    else for (int i = 0; i < 7; i++) begin
      checks++;
      if (wa[b+i] !== exp_addr(i, 4) || wd[b+i] !== exp_data(i, 4))
        begin errs++; $display("FAIL busy_write%0d: got %h/%h expected %h/%h", i, wa[b+i], wd[b+i], exp_addr(i, 4), exp_data(i, 4)); end
    end
    repeat (10) @(negedge clk);
    checks++;
    if (done_n - d0 !== 1 || Busy !== 0) begin errs++; $display("FAIL busy_no_rerun: got %0d done busy=%b expected 1 0", done_n - d0, Busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero();
    test_backpressure();
    test_start_busy();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
